// File: rtl/slave_spi_byte.sv
// -----------------------------------------------------------------------------
// slave_spi_byte
//
// SPI byte slave. All serial pins are oversampled by the system clock: sck,
// ss_n and mosi go through a short synchronizer, edges are found by comparing
// the last synchronizer stage with a one-cycle delayed copy, and a two-state
// FSM (IDLE / SHIFT) assembles MOSI bytes and shifts a locally loaded byte out
// on MISO, MSB first.
//
// The leading sck edge samples MOSI. The trailing sck edge advances MISO.
// A trailing edge that follows a completed frame reloads the output shifter,
// so frames can run back to back without releasing ss_n.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cpol          sck idle level (0: leading edge rising, 1: leading falling)
//   sck, ss_n,    asynchronous SPI pins from the master
//   mosi
//   miso, miso_oe serial data out and its pad enable (high while selected)
//   tx_data,      byte for the next frame and its write strobe
//   tx_load
//   tx_ready      holding register empty
//   rx_data,      last complete received byte and its 1-cycle update pulse
//   rx_valid
//   tx_underrun   sticky: a frame started with nothing loaded
//   busy          frame in progress
// -----------------------------------------------------------------------------
module slave_spi_byte #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. The three pins travel together as {ss_n, sck,
    // mosi} so mosi arrives at the last stage aligned with the sck edge
    // that samples it.
    // ------------------------------------------------------------------
    logic [2:0] sync_reg [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= {ss_n, sck, mosi};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    logic ss_s;
    logic sck_s;
    logic mosi_s;

    assign {ss_s, sck_s, mosi_s} = sync_reg[SYNC_STAGES-1];

    logic ss_d_reg;
    logic sck_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_d_reg  <= 1'b0;
            sck_d_reg <= 1'b0;
        end else begin
            ss_d_reg  <= ss_s;
            sck_d_reg <= sck_s;
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic ss_fall;
    logic ss_rise;

    assign sck_rise   = sck_s & ~sck_d_reg;
    assign sck_fall   = ~sck_s & sck_d_reg;
    assign lead_edge  = cpol ? sck_fall : sck_rise;
    assign trail_edge = cpol ? sck_rise : sck_fall;
    assign ss_fall    = ~ss_s & ss_d_reg;
    assign ss_rise    = ss_s & ~ss_d_reg;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_reg,    state_next;
    logic [CNT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0] hold_reg,     hold_next;
    logic              hold_full_reg, hold_full_next;
    logic [DATA_W-1:0] rx_data_reg,  rx_data_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              underrun_reg, underrun_next;
    logic              reload_now;
    logic              capture_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            underrun_reg  <= underrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        reload_now     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    reload_now   = 1'b1;
                end
            end
            SHIFT: begin
                // Deselect has priority over any sck edge seen in the same cycle.
                if (ss_rise) begin
                    state_next = IDLE;
                end else if (lead_edge && (bit_cnt_reg != CNT_FULL)) begin
                    rx_shift_next = {rx_shift_reg[DATA_W-2:0], mosi_s};
                    bit_cnt_next  = bit_cnt_reg + CNT_ONE;
                    // Last bit: publish the byte in the same cycle it completes.
                    if (bit_cnt_reg == (CNT_FULL - CNT_ONE)) begin
                        rx_data_next  = {rx_shift_reg[DATA_W-2:0], mosi_s};
                        rx_valid_next = 1'b1;
                    end
                end else if (trail_edge) begin
                    if (bit_cnt_reg == CNT_FULL) begin
                        // Trailing edge after a full frame starts the next one.
                        bit_cnt_next = '0;
                        reload_now   = 1'b1;
                    end else if (bit_cnt_reg != '0) begin
                        tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reload_now) begin
            tx_shift_next = hold_full_reg ? hold_reg : TX_IDLE;
        end
    end

    // Holding register. A load that coincides with a reload is judged
    // against the register's old contents, so the reload never sees it.
    always_comb begin
        capture_now    = tx_load & ~hold_full_reg;
        hold_next      = capture_now ? tx_data : hold_reg;
        hold_full_next = capture_now ? 1'b1 : (reload_now ? 1'b0 : hold_full_reg);
        underrun_next  = underrun_reg | (reload_now & ~hold_full_reg);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (state_reg == SHIFT);
    assign miso_oe     = busy;
    assign miso        = busy & tx_shift_reg[DATA_W-1];
    assign tx_ready    = ~hold_full_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign tx_underrun = underrun_reg;

endmodule
